// File: rtl/ncl_sync_adder_env.sv
// ncl_sync_adder_env: clocked boundary between host logic and an NCL dual-rail ripple adder array.
// Launches NULL/DATA operand wavefronts, captures completed results, and watches for stuck phases.
module ncl_sync_adder_env #(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic           clk,
    input  logic           init,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_a,
    input  logic [N-1:0]   in_b,
    input  logic           in_cin,
    output logic [2*N-1:0] A,
    output logic [2*N-1:0] B,
    output logic [1:0]     carryin,
    input  logic [N:0]     ack_in,
    input  logic [2*N-1:0] sum,
    input  logic [1:0]     carryout,
    output logic           sumCOMP,
    output logic           carryCOMP,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N:0]     out_sum,
    output logic           err
);
    localparam int W  = 3*N + 3;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic {SRC_NULL, SRC_DATA} src_t;
    typedef enum logic [1:0] {SNK_WAIT_DATA, SNK_HOLD, SNK_WAIT_NULL} snk_t;

    src_t           src, src_next;
    snk_t           snk, snk_next;
    logic [W-1:0]   sync_q [SYNC_STAGES];
    logic [N:0]     ack_s;
    logic [2*N+1:0] rails_s;
    logic           complete, all_null, bad;
    logic [N:0]     val;
    logic           complete_q, null_q;
    logic [N:0]     val_q;
    logic [N-1:0]   op_a, op_b;
    logic           op_c;
    logic           pending, comp, chg, watch;
    logic [TW-1:0]  timer;

    function automatic logic [2*N-1:0] dual(input logic [N-1:0] v);
        dual = '0;
        for (int i = 0; i < N; i++) dual[2*i +: 2] = {v[i], ~v[i]};
    endfunction

    assign ack_s     = sync_q[SYNC_STAGES-1][N:0];
    assign rails_s   = sync_q[SYNC_STAGES-1][W-1:N+1];
    assign all_null  = rails_s == '0;
    assign sumCOMP   = comp;
    assign carryCOMP = comp;

    // Per-bit synchronization is safe because NCL rails only move monotonically within a phase.
    always_ff @(posedge clk) begin
        if (init) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= {carryout, sum, ack_in};
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    always_comb begin
        complete = 1'b1;
        bad      = 1'b0;
        val      = '0;
        for (int i = 0; i <= N; i++) begin
            complete = complete & (rails_s[2*i] ^ rails_s[2*i+1]);
            bad      = bad | (rails_s[2*i] & rails_s[2*i+1]);
            val[i]   = rails_s[2*i+1];
        end
    end

    always_comb begin
        in_ready  = !init && src == SRC_NULL && in_valid && ack_s == '0;
        src_next  = src == SRC_NULL ? (in_ready ? SRC_DATA : SRC_NULL) : (&ack_s ? SRC_NULL : SRC_DATA);
        snk_next  = snk == SNK_WAIT_DATA ? (complete_q ? SNK_HOLD : SNK_WAIT_DATA) :
                    snk == SNK_HOLD      ? (out_ready ? SNK_WAIT_NULL : SNK_HOLD) :
                                           (null_q ? SNK_WAIT_DATA : SNK_WAIT_NULL);
        out_valid = snk == SNK_HOLD;
        chg       = src_next != src || snk_next != snk;
        // An empty array is only suspicious while a launched wavefront is still owed to the sink.
        watch     = src == SRC_DATA || (snk == SNK_WAIT_DATA && pending) || snk == SNK_WAIT_NULL;
    end

    always_ff @(posedge clk) begin
        if (init) begin
            src        <= SRC_NULL;
            snk        <= SNK_WAIT_DATA;
            op_a       <= '0;
            op_b       <= '0;
            op_c       <= 1'b0;
            A          <= '0;
            B          <= '0;
            carryin    <= '0;
            complete_q <= 1'b0;
            null_q     <= 1'b0;
            val_q      <= '0;
            out_sum    <= '0;
            comp       <= 1'b0;
            pending    <= 1'b0;
            timer      <= '0;
            err        <= 1'b0;
        end else begin
            src        <= src_next;
            snk        <= snk_next;
            if (in_ready) {op_a, op_b, op_c} <= {in_a, in_b, in_cin};
            A          <= src == SRC_DATA ? dual(op_a) : '0;
            B          <= src == SRC_DATA ? dual(op_b) : '0;
            carryin    <= src == SRC_DATA ? {op_c, ~op_c} : 2'b00;
            complete_q <= complete;
            null_q     <= all_null;
            val_q      <= val;
            if (snk == SNK_WAIT_DATA && complete_q) out_sum <= val_q;
            comp       <= snk == SNK_WAIT_NULL;
            pending    <= in_ready || (pending && !(snk == SNK_WAIT_DATA && complete_q));
            timer      <= chg ? '0 : (timer == TW'(TIMEOUT-1) ? timer : timer + 1'b1);
            err        <= err || bad || (watch && !chg && timer == TW'(TIMEOUT-1));
        end
    end
endmodule
